// File: rtl/boot_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg
// Shared definitions for the boot protocol: protocol phase encoding, the
// sync/end handshake bytes, the section terminator word, and helpers that the
// sender (and the on-chip loader) use to track phase and split words into
// bytes.
// -----------------------------------------------------------------------------
package boot_pkg;

  // Protocol phase as the receiver parses the word stream.
  typedef enum logic [2:0] {
    DATA_ADDR = 3'd0,
    DATA_VAL  = 3'd1,
    SP        = 3'd2,
    PC        = 3'd3,
    INSTR     = 3'd4
  } phase_e;

  localparam logic [7:0]  BOOT_SYNC_BYTE = 8'h99;
  localparam logic [7:0]  BOOT_END_BYTE  = 8'haa;
  localparam logic [31:0] BOOT_TERM_WORD = 32'hFFFF_FFFF;

  // Phase reached after the given word has been sent while in phase cur.
  function automatic phase_e next_phase(input phase_e cur, input logic [31:0] word);
    phase_e nxt;
    case (cur)
      DATA_ADDR: nxt = (word == BOOT_TERM_WORD) ? SP : DATA_VAL;
      DATA_VAL:  nxt = DATA_ADDR;
      SP:        nxt = PC;
      PC:        nxt = (word == BOOT_TERM_WORD) ? INSTR : PC;
      INSTR:     nxt = INSTR;
      default:   nxt = DATA_ADDR;
    endcase
    return nxt;
  endfunction

  // Byte idx of a word, byte 0 being bits [7:0].
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// 8N1 UART byte serializer. One bit lasts 2*CLK_PER_HALF_BIT cycles.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   data        - byte to send, taken when valid && ready
//   valid       - byte offered
//   ready       - serializer can take a byte
//   txd         - serial output (registered), idle high
// -----------------------------------------------------------------------------
module uart_tx_byte #(
  parameter int CLK_PER_HALF_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       txd
);

  localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    BIT_STOP = 4'd9;

  logic          busy_q, busy_d;
  logic [8:0]    shift_q, shift_d;   // remaining data bits with the stop bit on top
  logic [3:0]    bit_q, bit_d;       // 0 = start bit, 1..8 = data, 9 = stop
  logic [CW-1:0] cnt_q, cnt_d;
  logic          txd_q, txd_d;
  logic          bit_end_s;
  logic          accept_s;

  assign bit_end_s = busy_q && (cnt_q == CNT_LAST);
  // The final stop-bit cycle also counts as idle so that a waiting byte
  // starts right after the stop bit, with no gap between frames.
  assign ready    = !busy_q || (bit_end_s && (bit_q == BIT_STOP));
  assign accept_s = valid && ready;
  assign txd      = txd_q;

  // Next-state logic for the bit/cycle counters and the output bit.
  always_comb begin
    busy_d  = busy_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    txd_d   = txd_q;
    if (accept_s) begin
      busy_d  = 1'b1;
      shift_d = {1'b1, data};
      bit_d   = 4'd0;
      cnt_d   = '0;
      txd_d   = 1'b0;
    end else if (bit_end_s) begin
      cnt_d = '0;
      if (bit_q == BIT_STOP) begin
        busy_d = 1'b0;
        txd_d  = 1'b1;
      end else begin
        txd_d   = shift_q[0];
        shift_d = {1'b1, shift_q[8:1]};
        bit_d   = bit_q + 4'd1;
      end
    end else if (busy_q) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      txd_d = 1'b1;
    end
  end

  // Serializer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= 1'b0;
      shift_q <= 9'h1FF;
      bit_q   <= 4'd0;
      cnt_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      busy_q  <= busy_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: rtl/boot_sender.sv
// -----------------------------------------------------------------------------
// boot_sender
// Host-side boot image sender. After start it waits for the loader's sync
// byte, sends the image length (bytes) and every image word LSB first over
// UART, tracks the protocol phase, and finally waits for the end byte.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   start             - begin a session (IDLE/DONE/ERR only)
//   img_words         - word count, sampled on start
//   img_addr/img_data - synchronous image memory (1-cycle read latency)
//   rx_data/rx_ready  - bytes from the external UART receiver
//   txd               - UART output
//   busy/phase/done/err - status
// -----------------------------------------------------------------------------
module boot_sender
  import boot_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int IMG_AW           = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       img_words,
  output logic [IMG_AW-1:0] img_addr,
  input  logic [31:0]       img_data,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic              txd,
  output logic              busy,
  output logic [2:0]        phase,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_SYNC = 3'd1;
  localparam logic [2:0] S_SEND_LEN  = 3'd2;
  localparam logic [2:0] S_FETCH     = 3'd3;
  localparam logic [2:0] S_SEND_WORD = 3'd4;
  localparam logic [2:0] S_WAIT_END  = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;
  localparam logic [2:0] S_ERR       = 3'd7;

  localparam logic [IMG_AW-1:0] ADDR_ONE = IMG_AW'(1);

  logic [2:0]        state_q, state_d;
  logic [31:0]       word_q, word_d;          // word being serialized
  logic [31:0]       img_words_q, img_words_d;
  logic [31:0]       word_cnt_q, word_cnt_d;  // image words latched so far
  logic [IMG_AW-1:0] addr_q, addr_d;
  logic [2:0]        byte_idx_q, byte_idx_d;  // next byte to hand over; 4 = all handed
  logic              fetch_wait_q, fetch_wait_d;
  phase_e            phase_q, phase_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              tx_valid_s;
  logic              tx_ready_s;
  logic [7:0]        tx_byte_s;
  logic [31:0]       len_s;

  assign len_s = {img_words_q[29:0], 2'b00};

  uart_tx_byte #(
    .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
  ) u_tx (
    .clk  (clk),
    .reset(reset),
    .data (tx_byte_s),
    .valid(tx_valid_s),
    .ready(tx_ready_s),
    .txd  (txd)
  );

  // Session sequencing: sync wait, length, word fetch/send, end handshake.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    img_words_d  = img_words_q;
    word_cnt_d   = word_cnt_q;
    addr_d       = addr_q;
    byte_idx_d   = byte_idx_q;
    fetch_wait_d = fetch_wait_q;
    phase_d      = phase_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    tx_valid_s   = 1'b0;
    tx_byte_s    = word_byte(word_q, byte_idx_q[1:0]);

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          img_words_d  = img_words;
          word_cnt_d   = 32'd0;
          addr_d       = '0;
          byte_idx_d   = 3'd0;
          fetch_wait_d = 1'b0;
          phase_d      = DATA_ADDR;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          err_d        = 1'b0;
          state_d      = S_WAIT_SYNC;
        end else begin
          state_d = state_q;
        end
      end

      S_WAIT_SYNC: begin
        // The first length byte goes to the serializer in the same cycle the
        // sync byte is seen, so its start bit follows one cycle later.
        if (rx_ready && (rx_data == BOOT_SYNC_BYTE) && tx_ready_s) begin
          tx_valid_s = 1'b1;
          tx_byte_s  = len_s[7:0];
          word_d     = len_s;
          byte_idx_d = 3'd1;
          state_d    = S_SEND_LEN;
        end else begin
          state_d = state_q;
        end
      end

      S_SEND_LEN, S_SEND_WORD: begin
        if (byte_idx_q != 3'd4) begin
          tx_valid_s = 1'b1;
          if (tx_ready_s) begin
            byte_idx_d = byte_idx_q + 3'd1;
          end else begin
            byte_idx_d = byte_idx_q;
          end
        end else if (word_cnt_q == img_words_q) begin
          // Covers both the empty image (count still 0 after the length)
          // and the last word; leave only once its stop bit has gone out.
          if (tx_ready_s) begin
            state_d = S_WAIT_END;
          end else begin
            state_d = state_q;
          end
        end else begin
          // Prefetch the next word while the last byte is still on the
          // line, keeping the byte stream gap-free.
          if (state_q == S_SEND_WORD) begin
            addr_d = addr_q + ADDR_ONE;
          end else begin
            addr_d = '0;
          end
          fetch_wait_d = 1'b0;
          state_d      = S_FETCH;
        end
      end

      S_FETCH: begin
        if (!fetch_wait_q) begin
          fetch_wait_d = 1'b1;
        end else begin
          word_d       = img_data;
          phase_d      = next_phase(phase_q, img_data);
          word_cnt_d   = word_cnt_q + 32'd1;
          byte_idx_d   = 3'd0;
          fetch_wait_d = 1'b0;
          state_d      = S_SEND_WORD;
        end
      end

      S_WAIT_END: begin
        if (rx_ready) begin
          busy_d = 1'b0;
          if ((rx_data == BOOT_END_BYTE) && (phase_q == INSTR)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      word_q       <= 32'd0;
      img_words_q  <= 32'd0;
      word_cnt_q   <= 32'd0;
      addr_q       <= '0;
      byte_idx_q   <= 3'd0;
      fetch_wait_q <= 1'b0;
      phase_q      <= DATA_ADDR;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      img_words_q  <= img_words_d;
      word_cnt_q   <= word_cnt_d;
      addr_q       <= addr_d;
      byte_idx_q   <= byte_idx_d;
      fetch_wait_q <= fetch_wait_d;
      phase_q      <= phase_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign img_addr = addr_q;
  assign busy     = busy_q;
  assign phase    = phase_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_boot_sender.sv
module tb_boot_sender;
  import boot_pkg::*;

  localparam int HB    = 4;
  localparam int AW    = 4;
  localparam int FRAME = 80;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   img_words;
  logic [AW-1:0] img_addr;
  logic [31:0]   img_data;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          txd;
  logic          busy;
  logic [2:0]    phase;
  logic          done;
  logic          err;

  logic [31:0] mem [16];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int prev_s;

  typedef struct {
    logic [31:0] word;
    logic [2:0]  exp_phase;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) img_data <= mem[img_addr];

  boot_sender #(.CLK_PER_HALF_BIT(HB), .IMG_AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .img_words(img_words),
    .img_addr(img_addr), .img_data(img_data), .rx_data(rx_data),
    .rx_ready(rx_ready), .txd(txd), .busy(busy), .phase(phase),
    .done(done), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] n);
    @(negedge clk);
    img_words = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sync byte: txd must be idle while it is offered and low one cycle later.
  task automatic send_sync();
    @(negedge clk);
    rx_data = BOOT_SYNC_BYTE;
    rx_ready = 1'b1;
    check("txd idle before sync", {31'd0, txd}, 32'd1);
    @(negedge clk);
    rx_ready = 1'b0;
    check("start bit 1 cycle after sync", {31'd0, txd}, 32'd0);
  endtask

  task automatic wait_low(output int s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (txd === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    s = cyc;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL start bit timeout: txd=%0b after 300 cycles, required 0", txd);
    end
  endtask

  // Samples one 80-cycle frame starting at the current negedge.
  task automatic recv_byte(output logic [7:0] b, output int s, output int low_run);
    bit ok;
    logic [FRAME-1:0] fr;
    bit run;
    b = 8'h00;
    low_run = 0;
    wait_low(s, ok);
    if (ok) begin
      fr = '0;
      fr[0] = txd;
      for (int k = 1; k < FRAME; k++) begin
        @(negedge clk);
        fr[k] = txd;
      end
      for (int i = 0; i < 8; i++) b[i] = fr[8 * (i + 1) + 4];
      check("frame start/stop", {30'd0, fr[76], fr[4]}, 32'd2);
      run = 1'b1;
      for (int k = 0; k < FRAME; k++) begin
        if (run && fr[k] == 1'b0) low_run++;
        else run = 1'b0;
      end
      if (prev_s >= 0) check("byte spacing", s - prev_s, FRAME);
      prev_s = s;
    end
  endtask

  task automatic recv_word(output logic [31:0] w, output int lr0, input bit chk_ph,
                           input logic [2:0] exp_ph);
    logic [7:0] b;
    int s;
    int lr;
    recv_byte(b, s, lr0);
    w[7:0] = b;
    if (chk_ph) check("phase", {29'd0, phase}, {29'd0, exp_ph});
    for (int j = 1; j < 4; j++) begin
      recv_byte(b, s, lr);
      w[8 * j +: 8] = b;
    end
  endtask

  task automatic recv_session(input int n, input logic [31:0] exp_len, input bit chk_ph);
    logic [31:0] w;
    int lr;
    prev_s = -1;
    recv_word(w, lr, 1'b0, 3'd0);
    check("length word", w, exp_len);
    for (int i = 0; i < n; i++) begin
      recv_word(w, lr, chk_ph, vecs[i].exp_phase);
      check("image word", w, mem[i]);
      if (chk_ph && i == 1) check("start bit width", lr, 8);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic count_low(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
  endtask

  task automatic load_happy();
    for (int i = 0; i < 8; i++) mem[i] = vecs[i].word;
  endtask

  initial begin
    int lows;
    int s;
    int lr;
    logic [7:0] b;

    vecs[0] = '{32'h0000_0100, 3'(DATA_VAL)};
    vecs[1] = '{32'hDEAD_BEEF, 3'(DATA_ADDR)};
    vecs[2] = '{32'hFFFF_FFFF, 3'(SP)};
    vecs[3] = '{32'h0000_8000, 3'(PC)};
    vecs[4] = '{32'h0000_0000, 3'(PC)};
    vecs[5] = '{32'hFFFF_FFFF, 3'(INSTR)};
    vecs[6] = '{32'h0000_0013, 3'(INSTR)};
    vecs[7] = '{32'h0000_0093, 3'(INSTR)};
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    load_happy();

    reset = 1'b1; start = 1'b0; rx_ready = 1'b0; rx_data = 8'h00; img_words = 32'd0;
    prev_s = -1;
    repeat (3) @(negedge clk);
    check("reset txd", {31'd0, txd}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset img_addr", {28'd0, img_addr}, 32'd0);
    check("reset phase", {29'd0, phase}, 32'd0);
    reset = 1'b0;

    // Happy path with sync filtering.
    pulse_start(32'd8);
    check("busy after start", {31'd0, busy}, 32'd1);
    send_rx(8'h55);
    send_rx(8'h00);
    count_low(30, lows);
    check("txd idle before sync byte", lows, 0);
    send_sync();
    recv_session(8, 32'h0000_0020, 1'b1);
    check("happy final phase", {29'd0, phase}, {29'd0, 3'(INSTR)});
    check("busy in WAIT_END", {31'd0, busy}, 32'd1);
    send_rx(BOOT_END_BYTE);
    check("happy done", {31'd0, done}, 32'd1);
    check("happy busy", {31'd0, busy}, 32'd0);
    check("happy err", {31'd0, err}, 32'd0);

    // Bad end byte, restarted from DONE.
    pulse_start(32'd8);
    check("restart clears done", {31'd0, done}, 32'd0);
    send_sync();
    recv_session(8, 32'h0000_0020, 1'b0);
    send_rx(8'h11);
    check("bad end err", {31'd0, err}, 32'd1);
    check("bad end done", {31'd0, done}, 32'd0);
    check("bad end busy", {31'd0, busy}, 32'd0);

    // Truncated image, restarted from ERR.
    mem[0] = 32'h0000_0100; mem[1] = 32'h0000_0005; mem[2] = 32'hFFFF_FFFF;
    pulse_start(32'd3);
    check("restart clears err", {31'd0, err}, 32'd0);
    send_sync();
    recv_session(3, 32'h0000_000C, 1'b0);
    check("truncated phase", {29'd0, phase}, {29'd0, 3'(SP)});
    send_rx(BOOT_END_BYTE);
    check("truncated err", {31'd0, err}, 32'd1);
    check("truncated done", {31'd0, done}, 32'd0);

    // Reset during the third byte of the second image word.
    load_happy();
    pulse_start(32'd8);
    send_sync();
    prev_s = -1;
    for (int i = 0; i < 10; i++) recv_byte(b, s, lr);
    wait_low(s, lr[0]);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid reset txd", {31'd0, txd}, 32'd1);
    check("mid reset busy", {31'd0, busy}, 32'd0);
    check("mid reset img_addr", {28'd0, img_addr}, 32'd0);
    reset = 1'b0;
    count_low(100, lows);
    check("txd idle after reset", lows, 0);
    pulse_start(32'd8);
    send_sync();
    recv_session(8, 32'h0000_0020, 1'b1);
    send_rx(BOOT_END_BYTE);
    check("resend done", {31'd0, done}, 32'd1);
    check("resend err", {31'd0, err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
